flow_output_demux: RTL and testbench
====================================

# flow_output_demux

Receiving end of the tagged multi-flow output stream produced by the multi-flow interpolation accelerator (`top_ms`). It accepts `{flow_tag, pixel}` writes on a single write interface and exerts per-flow back-pressure through a `full` vector. It steers each pixel into a per-flow FWFT FIFO and counts the pixels of each flow against a programmed block size. When a flow's block completes it raises a one-cycle `done` pulse, so downstream consumers can drain each flow independently.

## Interface
- `FLUX`, 4: number of flows; tag width `TAG_W = $clog2(FLUX)`.
- `DEPTH`, 16: per-flow FIFO depth in entries, power of two.
- `DATA_W`, 8: pixel width.
- `CNT_W`, 13: block-size and pixel-counter width (max 4096 = 64x64).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_din`  in  TAG_W+DATA_W  `{tag, pixel}`; the tag is in the MSBs.
- `in_write`  in  1  write strobe for `in_din`.
- `in_full`  out  FLUX  per-flow FIFO full.
- `cfg_din`  in  TAG_W+CNT_W  `{tag, block_size}`.
- `cfg_write`  in  1  arms the tagged flow with `block_size`.
- `rd`  in  FLUX  per-flow pop.
- `dout`  out  FLUX*DATA_W  per-flow head pixel; flow f occupies `[f*DATA_W +: DATA_W]`.
- `empty`  out  FLUX  per-flow FIFO empty.
- `done`  out  FLUX  one-cycle pulse when the flow's block has been fully accepted.
- `err_drop`  out  1  sticky: a write was discarded.
- `err_cfg`  out  1  sticky: an illegal configuration write occurred.

## Operation
- Per-flow state machine with states IDLE, ARMED and DONE.
  - IDLE -> ARMED on `cfg_write` with a matching tag and `block_size` != 0. This loads `size[f]` and clears `cnt[f]`.
  - `cfg_write` with `block_size` == 0, or issued to an ARMED flow: ignored, sets `err_cfg`.
  - ARMED: each accepted write stores the pixel in FIFO f and increments `cnt[f]`.
  - When `cnt[f]+1 == size[f]` on an accepted write, the flow goes to DONE.
  - DONE -> IDLE unconditionally on the next cycle. `done[f]` is high only while the flow is in DONE.
  - A `cfg_write` to a flow that is in DONE is accepted and moves the flow to ARMED (re-arm is allowed in the DONE cycle).
- A write is accepted only if the tag is < FLUX, the flow is ARMED, and `in_full[tag]` is 0. Any other write is discarded and sets `err_drop`.
- FIFOs:
  - FWFT: `dout[f]` shows the head entry when `empty[f]` = 0, and reads 0 when empty.
  - `rd[f]` while empty is ignored.
  - FIFO data is independent of flow state; pixels remain readable after the flow returns to IDLE.
- Pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2*DEPTH.
  - `empty` = pointers equal.
  - `full` = addresses equal and MSBs differ.
- `cnt` never exceeds `size`. Writes beyond the block are discarded because the flow is no longer ARMED.

## Timing
- Reset (asynchronous, `rst` = 0):
  - `in_full` = 0, `empty` = all 1, `dout` = 0, `done` = 0, `err_*` = 0.
  - All flows IDLE, pointers 0, counters 0.
- Reset asserted mid-block discards all FIFO contents and configuration immediately.
- Write latency: a pixel accepted at edge k gives `empty[f]` = 0 and valid `dout[f]` after edge k.
- `in_full[f]` rises after the edge that writes entry DEPTH. It falls after the edge of the first `rd[f]`.
- Simultaneous write and read on the same flow:
  - Not full: both happen, occupancy is unchanged.
  - Full: the write is discarded and the read happens.
- Simultaneous write and read on the same flow when empty: the write lands, the read is ignored.
- `done[f]` is asserted the cycle after the edge that accepted the last pixel of the block, for exactly one cycle.
- `cfg_write` and `in_write` to the same IDLE flow on the same edge: the configuration is applied and the write is discarded (`err_drop` = 1).
- Flows are fully independent; there is no cross-flow ordering or priority.

## Test plan
- Reset, then arm flow 0 with size 4 and write pixels 0x11..0x14.
  - `empty[0]` falls after the first write and `dout[0]` = 0x11.
  - `done[0]` pulses once on the cycle after the 4th write.
  - Popping 4 times yields 0x11, 0x12, 0x13, 0x14, then `empty[0]` = 1.
- Arm flow 2 with size 64 and write 16 pixels without reading.
  - `in_full[2]` = 1 and the 17th write is discarded with `err_drop` = 1.
  - One `rd[2]` clears `full`; the remaining 48 pixels are then accepted and `done[2]` fires after pixel 64.
- Interleave blocks of 8 pixels round-robin across flows 0..3, with sizes 64/32/16/8, while reading continuously.
  - Each flow's output order matches its input order.
  - `done[3]` pulses first; all four `done` pulses occur exactly once.
- Write to an unarmed flow 1, and write with tag 3 when `FLUX` = 3: both are discarded, `err_drop` = 1, FIFOs stay empty.
- Arm flow 0 twice: second `cfg_write` sets `err_cfg`. Then apply `cfg_write` in the `done[0]` cycle: flow 0 re-arms and accepts its next block.
- Assert reset with 5 pixels queued in flow 1: `empty[1]` = 1, `dout` = 0, `done` = 0 and flow 1 is IDLE immediately.

Source files
------------

// File: rtl/flow_output_demux.sv
// -----------------------------------------------------------------------------
// flow_output_demux
//
// Receives the tagged multi-flow pixel stream ({flow_tag, pixel}) and steers
// each pixel into a per-flow first-word-fall-through FIFO. Each flow is armed
// with a block size and counts its accepted pixels. When the last pixel of a
// block is accepted, the flow emits a one-cycle done pulse so that downstream
// consumers can drain every flow on its own schedule.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   in_din     {tag, pixel}; the tag sits in the MSBs
//   in_write   write strobe for in_din
//   in_full    per-flow FIFO full (back-pressure)
//   cfg_din    {tag, block_size}
//   cfg_write  arms the tagged flow with block_size
//   rd         per-flow pop
//   dout       per-flow head pixel; flow f at [f*DATA_W +: DATA_W], 0 if empty
//   empty      per-flow FIFO empty
//   done       per-flow one-cycle pulse after the block's last pixel
//   err_drop   sticky: a write was discarded
//   err_cfg    sticky: an illegal configuration write occurred
// -----------------------------------------------------------------------------
module flow_output_demux #(
  parameter  int FLUX   = 4,
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 13,
  localparam int TAG_W  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_W+DATA_W-1:0]  in_din,
  input  logic                     in_write,
  output logic [FLUX-1:0]          in_full,
  input  logic [TAG_W+CNT_W-1:0]   cfg_din,
  input  logic                     cfg_write,
  input  logic [FLUX-1:0]          rd,
  output logic [FLUX*DATA_W-1:0]   dout,
  output logic [FLUX-1:0]          empty,
  output logic [FLUX-1:0]          done,
  output logic                     err_drop,
  output logic                     err_cfg
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit distinguishes full from empty when addresses match.
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } flow_state_e;

  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_pixel;
  logic [TAG_W-1:0]  cfg_tag;
  logic [CNT_W-1:0]  cfg_size;

  assign in_tag   = in_din[TAG_W+DATA_W-1:DATA_W];
  assign in_pixel = in_din[DATA_W-1:0];
  assign cfg_tag  = cfg_din[TAG_W+CNT_W-1:CNT_W];
  assign cfg_size = cfg_din[CNT_W-1:0];

  // push[f]: write accepted into flow f this cycle.
  // cfg_ok[f]: legal configuration of flow f this cycle.
  logic [FLUX-1:0] push;
  logic [FLUX-1:0] cfg_ok;

  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    flow_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  size_q, size_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A tag outside 0..FLUX-1 never matches any flow, so it is always dropped.
    assign push[f]   = in_write && (in_tag == TAG_W'(f)) &&
                       (state_q == S_ARMED) && !fifo_full;
    // A DONE flow may be re-armed in its done cycle; only ARMED rejects.
    assign cfg_ok[f] = cfg_write && (cfg_tag == TAG_W'(f)) &&
                       (cfg_size != '0) && (state_q != S_ARMED);
    assign pop       = rd[f] && !fifo_empty;

    always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      size_d   = size_q;
      wr_ptr_d = wr_ptr_q + PW'(push[f]);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (cfg_ok[f]) begin
            state_d = S_ARMED;
            size_d  = cfg_size;
            cnt_d   = '0;
          end
        end
        S_ARMED: begin
          if (push[f]) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == size_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        size_q   <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        size_q   <= size_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // NOTE: the storage array is deliberately not reset; resetting the
    // pointers empties the FIFO and dout is forced to 0 while empty, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
      if (push[f]) mem_q[wr_ptr_q[AW-1:0]] <= in_pixel;
    end

    assign in_full[f]                 = fifo_full;
    assign empty[f]                   = fifo_empty;
    assign done[f]                    = (state_q == S_DONE);
    assign dout[f*DATA_W +: DATA_W]   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Sticky error flags.
  logic err_drop_q, err_drop_d;
  logic err_cfg_q, err_cfg_d;

  always_comb begin
    err_drop_d = err_drop_q || (in_write && (push == '0));
    err_cfg_d  = err_cfg_q  || (cfg_write && (cfg_ok == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_drop_q <= 1'b0;
      err_cfg_q  <= 1'b0;
    end else begin
      err_drop_q <= err_drop_d;
      err_cfg_q  <= err_cfg_d;
    end
  end

  assign err_drop = err_drop_q;
  assign err_cfg  = err_cfg_q;

endmodule

// File: tb/tb_flow_output_demux.sv
// -----------------------------------------------------------------------------
// tb_flow_output_demux
//
// Self-checking bench for flow_output_demux. A behavioural model (one pixel
// queue per flow plus an armed flag and a remaining-pixel count) predicts
// every output after every clock edge. Directed table and sequences cover the
// corner cases; a randomized phase exercises arbitrary mixes of writes,
// configuration and reads. A second instance with FLUX = 3 checks the
// out-of-range tag.
// -----------------------------------------------------------------------------
module tb_flow_output_demux;

  localparam int FLUX  = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [9:0]  in_din;
  logic        in_write;
  logic [3:0]  in_full;
  logic [14:0] cfg_din;
  logic        cfg_write;
  logic [3:0]  rd;
  logic [31:0] dout;
  logic [3:0]  empty;
  logic [3:0]  done;
  logic        err_drop;
  logic        err_cfg;

  // Three-flow instance: tag 3 is out of range.
  logic [9:0]  d3_in_din;
  logic        d3_in_write;
  logic [2:0]  d3_in_full;
  logic [14:0] d3_cfg_din;
  logic        d3_cfg_write;
  logic [2:0]  d3_rd;
  logic [23:0] d3_dout;
  logic [2:0]  d3_empty;
  logic [2:0]  d3_done;
  logic        d3_err_drop;
  logic        d3_err_cfg;

  flow_output_demux #(.FLUX(4), .DEPTH(16), .DATA_W(8), .CNT_W(13)) u_dut (
    .clk(clk), .rst(rst),
    .in_din(in_din), .in_write(in_write), .in_full(in_full),
    .cfg_din(cfg_din), .cfg_write(cfg_write),
    .rd(rd), .dout(dout), .empty(empty), .done(done),
    .err_drop(err_drop), .err_cfg(err_cfg)
  );

  flow_output_demux #(.FLUX(3), .DEPTH(16), .DATA_W(8), .CNT_W(13)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_din(d3_in_din), .in_write(d3_in_write), .in_full(d3_in_full),
    .cfg_din(d3_cfg_din), .cfg_write(d3_cfg_write),
    .rd(d3_rd), .dout(d3_dout), .empty(d3_empty), .done(d3_done),
    .err_drop(d3_err_drop), .err_cfg(d3_err_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq [FLUX][$];
  bit         m_armed [FLUX];
  int         m_rem   [FLUX];
  bit         m_done  [FLUX];
  bit         m_err_drop;
  bit         m_err_cfg;

  int done_cnt [FLUX];
  int first_done;

  task automatic model_reset();
    for (int f = 0; f < FLUX; f++) begin
      mq[f].delete();
      m_armed[f] = 1'b0;
      m_rem[f]   = 0;
      m_done[f]  = 1'b0;
    end
    m_err_drop = 1'b0;
    m_err_cfg  = 1'b0;
  endtask

  // Predicts the effect of the next clock edge from the currently driven inputs.
  task automatic model_step();
    logic [1:0]  wt;
    logic [1:0]  ct;
    logic [12:0] cs;
    bit          wacc;
    bit          cfg_legal;
    wt = in_din[9:8];
    ct = cfg_din[14:13];
    cs = cfg_din[12:0];
    wacc      = in_write && m_armed[wt] && (mq[wt].size() < DEPTH);
    cfg_legal = cfg_write && (cs != 0) && !m_armed[ct];
    if (in_write && !wacc) m_err_drop = 1'b1;
    if (cfg_write && !cfg_legal) m_err_cfg = 1'b1;
    for (int f = 0; f < FLUX; f++) begin
      m_done[f] = 1'b0;
      if (rd[f] && mq[f].size() > 0) void'(mq[f].pop_front());
    end
    if (wacc) begin
      mq[wt].push_back(in_din[7:0]);
      m_rem[wt]--;
      if (m_rem[wt] == 0) begin
        m_armed[wt] = 1'b0;
        m_done[wt]  = 1'b1;
      end
    end
    if (cfg_legal) begin
      m_armed[ct] = 1'b1;
      m_rem[ct]   = int'(cs);
    end
  endtask

  task automatic model_compare();
    logic [3:0]  e_empty, e_full, e_done;
    logic [31:0] e_dout;
    for (int f = 0; f < FLUX; f++) begin
      e_empty[f]       = (mq[f].size() == 0);
      e_full[f]        = (mq[f].size() == DEPTH);
      e_done[f]        = m_done[f];
      e_dout[f*8 +: 8] = (mq[f].size() > 0) ? mq[f][0] : 8'h00;
    end
    check("model_empty",    64'(empty),    64'(e_empty));
    check("model_full",     64'(in_full),  64'(e_full));
    check("model_done",     64'(done),     64'(e_done));
    check("model_dout",     64'(dout),     64'(e_dout));
    check("model_err_drop", 64'(err_drop), 64'(m_err_drop));
    check("model_err_cfg",  64'(err_cfg),  64'(m_err_cfg));
  endtask

  task automatic idle_inputs();
    in_write     = 1'b0;
    in_din       = '0;
    cfg_write    = 1'b0;
    cfg_din      = '0;
    rd           = '0;
    d3_in_write  = 1'b0;
    d3_in_din    = '0;
    d3_cfg_write = 1'b0;
    d3_cfg_din   = '0;
    d3_rd        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus, advances one edge, checks against the model.
  task automatic apply(input logic wr, input logic [1:0] wtag, input logic [7:0] wpix,
                       input logic cw, input logic [1:0] ctag, input logic [12:0] csize,
                       input logic [3:0] rdv);
    in_write  = wr;
    in_din    = {wtag, wpix};
    cfg_write = cw;
    cfg_din   = {ctag, csize};
    rd        = rdv;
    model_step();
    tick();
    in_write  = 1'b0;
    cfg_write = 1'b0;
    rd        = '0;
    model_compare();
    for (int f = 0; f < FLUX; f++) begin
      if (done[f]) begin
        done_cnt[f]++;
        if (first_done < 0) first_done = f;
      end
    end
  endtask

  // Asserts reset between clock edges and checks that it acts immediately.
  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    check("rst_empty",    64'(empty),       64'hF);
    check("rst_full",     64'(in_full),     64'h0);
    check("rst_done",     64'(done),        64'h0);
    check("rst_dout",     64'(dout),        64'h0);
    check("rst_err_drop", 64'(err_drop),    64'h0);
    check("rst_err_cfg",  64'(err_cfg),     64'h0);
    check("rst_d3_empty", 64'(d3_empty),    64'h7);
    model_reset();
    #1 rst = 1'b1;
    tick();
    for (int f = 0; f < FLUX; f++) done_cnt[f] = 0;
    first_done = -1;
  endtask

  typedef struct packed {
    logic        wr;
    logic [7:0]  wpix;
    logic        cw;
    logic [12:0] csize;
    logic        rd0;
    logic        e_empty0;
    logic        e_done0;
    logic [7:0]  e_dout0;
    logic        e_drop;
  } vec_t;

  vec_t tbl [11];

  initial begin
    rst = 1'b0;
    idle_inputs();
    do_reset();

    // ---- Flow 0, size 4: table-driven vectors ----
    //            wr   wpix   cw   size   rd0  empty done dout  drop
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 13'd4, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    tbl[2]  = '{1'b1, 8'h12, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 8'h13, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 8'h14, 1'b0, 13'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 13'd0, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 13'd0, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 13'd0, 1'b1, 1'b0, 1'b0, 8'h14, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 13'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 8'h15, 1'b0, 13'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 13'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].wr, 2'd0, tbl[i].wpix, tbl[i].cw, 2'd0, tbl[i].csize, {3'b000, tbl[i].rd0});
      check($sformatf("tbl%0d_empty0", i), 64'(empty[0]), 64'(tbl[i].e_empty0));
      check($sformatf("tbl%0d_done0", i),  64'(done[0]),  64'(tbl[i].e_done0));
      check($sformatf("tbl%0d_dout0", i),  64'(dout[7:0]), 64'(tbl[i].e_dout0));
      check($sformatf("tbl%0d_drop", i),   64'(err_drop), 64'(tbl[i].e_drop));
    end
    check("tbl_done0_once", 64'(done_cnt[0]), 64'd1);

    // ---- Flow 2, size 64: fill to full, overflow, then stream the rest ----
    do_reset();
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 13'd64, 4'b0000);
    for (int i = 0; i < 16; i++) apply(1'b1, 2'd2, 8'(8'h40 + i), 1'b0, 2'd0, 13'd0, 4'b0000);
    check("f2_full_at_16", 64'(in_full[2]), 64'd1);
    check("f2_no_drop_yet", 64'(err_drop), 64'd0);
    apply(1'b1, 2'd2, 8'hEE, 1'b0, 2'd0, 13'd0, 4'b0000);
    check("f2_drop_17", 64'(err_drop), 64'd1);
    check("f2_head_40", 64'(dout[23:16]), 64'h40);
    apply(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 13'd0, 4'b0100);
    check("f2_full_clear", 64'(in_full[2]), 64'd0);
    check("f2_head_41", 64'(dout[23:16]), 64'h41);
    for (int i = 16; i < 64; i++) begin
      apply(1'b1, 2'd2, 8'(8'h40 + i), 1'b0, 2'd0, 13'd0, 4'b0100);
      if (i == 62) check("f2_no_early_done", 64'(done[2]), 64'd0);
    end
    check("f2_done_after_64", 64'(done[2]), 64'd1);
    apply(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 13'd0, 4'b0100);
    check("f2_done_once", 64'(done_cnt[2]), 64'd1);

    // ---- Round-robin blocks of 8, sizes 64/32/16/8, continuous reading ----
    do_reset();
    begin
      int sz [FLUX];
      int sent [FLUX];
      sz = '{64, 32, 16, 8};
      for (int f = 0; f < FLUX; f++) begin
        sent[f] = 0;
        apply(1'b0, 2'd0, 8'h00, 1'b1, 2'(f), 13'(sz[f]), 4'b0000);
      end
      for (int r = 0; r < 8; r++) begin
        for (int f = 0; f < FLUX; f++) begin
          if (sent[f] < sz[f]) begin
            for (int k = 0; k < 8; k++) begin
              apply(1'b1, 2'(f), 8'(f * 64 + sent[f]), 1'b0, 2'd0, 13'd0, 4'hF);
              sent[f]++;
            end
          end
        end
      end
      for (int i = 0; i < 4; i++) apply(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 13'd0, 4'hF);
      for (int f = 0; f < FLUX; f++) check($sformatf("rr_done_once_%0d", f), 64'(done_cnt[f]), 64'd1);
      check("rr_first_done_is_3", 64'(first_done), 64'd3);
      check("rr_all_empty", 64'(empty), 64'hF);
      check("rr_no_errors", 64'({err_drop, err_cfg}), 64'd0);
    end

    // ---- Writes to an unarmed flow and to an out-of-range tag ----
    do_reset();
    apply(1'b1, 2'd1, 8'h5A, 1'b0, 2'd0, 13'd0, 4'b0000);
    check("unarmed_drop", 64'(err_drop), 64'd1);
    check("unarmed_empty", 64'(empty), 64'hF);
    check("d3_drop_before", 64'(d3_err_drop), 64'd0);
    d3_in_write = 1'b1;
    d3_in_din   = {2'd3, 8'hA5};
    tick();
    d3_in_write = 1'b0;
    check("d3_tag3_drop", 64'(d3_err_drop), 64'd1);
    check("d3_tag3_empty", 64'(d3_empty), 64'h7);
    check("d3_no_cfg_err", 64'(d3_err_cfg), 64'd0);

    // ---- Same-edge cfg and write, re-arm in done cycle, double arm ----
    do_reset();
    apply(1'b1, 2'd1, 8'h77, 1'b1, 2'd1, 13'd5, 4'b0000);
    check("same_edge_drop", 64'(err_drop), 64'd1);
    check("same_edge_empty1", 64'(empty[1]), 64'd1);
    check("same_edge_cfg_ok", 64'(err_cfg), 64'd0);
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 13'd2, 4'b0000);
    apply(1'b1, 2'd0, 8'h21, 1'b0, 2'd0, 13'd0, 4'b0000);
    apply(1'b1, 2'd0, 8'h22, 1'b0, 2'd0, 13'd0, 4'b0000);
    check("rearm_done_cycle", 64'(done[0]), 64'd1);
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 13'd3, 4'b0000);
    check("rearm_no_cfg_err", 64'(err_cfg), 64'd0);
    check("rearm_done_low", 64'(done[0]), 64'd0);
    for (int i = 0; i < 3; i++) apply(1'b1, 2'd0, 8'(8'h23 + i), 1'b0, 2'd0, 13'd0, 4'b0000);
    check("rearm_block_done", 64'(done[0]), 64'd1);
    check("rearm_occupancy", 64'(mq[0].size()), 64'd5);
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 13'd9, 4'b0000);
    check("arm_once_ok", 64'(err_cfg), 64'd0);
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 13'd9, 4'b0000);
    check("arm_twice_err", 64'(err_cfg), 64'd1);

    // ---- Reset mid-block with 5 pixels queued in flow 1 ----
    do_reset();
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 13'd10, 4'b0000);
    for (int i = 0; i < 5; i++) apply(1'b1, 2'd1, 8'(8'h90 + i), 1'b0, 2'd0, 13'd0, 4'b0000);
    check("mid_queued", 64'(empty[1]), 64'd0);
    do_reset();
    apply(1'b1, 2'd1, 8'h99, 1'b0, 2'd0, 13'd0, 4'b0000);
    check("mid_flow1_idle_drop", 64'(err_drop), 64'd1);
    check("mid_flow1_empty", 64'(empty[1]), 64'd1);

    // ---- Randomized phase against the model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      apply(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
            13'($urandom_range(0, 24)), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
